// File: rtl/mult_char_pkg.sv
// Shared definitions for the approximate-multiplier characterisation blocks.
package mult_char_pkg;

  localparam int DEF_WIDTH       = 6;
  localparam int DEF_NUM_SAMPLES = 4096;
  localparam int PROD_W          = 2 * DEF_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } acc_state_t;

endpackage

// File: rtl/mult_error_accumulator_abs_diff.sv
// Unsigned absolute difference |a - b|, purely combinational.
module abs_diff
  import mult_char_pkg::*;
#(
  parameter int W = PROD_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff
);

  // Subtract the smaller operand from the larger so the result never wraps.
  always_comb begin
    diff = (a >= b) ? (a - b) : (b - a);
  end

endmodule

// File: rtl/mult_error_accumulator.sv
// Collects error statistics of an approximate multiplier over a fixed-length run.
// Samples flow through a 3-stage pipeline: exact product, absolute error, stats update.
module mult_error_accumulator
  import mult_char_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int NUM_SAMPLES = DEF_NUM_SAMPLES,
  parameter int SUM_W       = 24,
  parameter int CNT_W       = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  input  logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     sample_count,
  output logic [CNT_W-1:0]     err_count,
  output logic [SUM_W-1:0]     err_sum,
  output logic [2*WIDTH-1:0]   err_max
);

  localparam int PW    = 2 * WIDTH;
  localparam int ADD_W = ((SUM_W > PW) ? SUM_W : PW) + 1;
  localparam logic [CNT_W-1:0] NUM_S   = CNT_W'(NUM_SAMPLES);
  localparam logic [SUM_W-1:0] SUM_MAX = '1;

  acc_state_t       state;
  acc_state_t       next_state;
  logic [CNT_W-1:0] accepted;
  logic             accept;
  logic             clear_run;

  logic             s1_valid;
  logic [PW-1:0]    s1_exact;
  logic [PW-1:0]    s1_approx;
  logic             s2_valid;
  logic [PW-1:0]    s2_abs_err;
  logic [PW-1:0]    abs_err_comb;

  logic [ADD_W-1:0] sum_wide;
  logic [SUM_W-1:0] sum_sat;

  // Handshake and status decode; a start outside RUN opens a fresh run.
  always_comb begin
    in_ready  = (state == ST_RUN) && (accepted < NUM_S);
    accept    = in_valid && in_ready;
    busy      = (state == ST_RUN);
    done      = (state == ST_DONE);
    clear_run = start && (state != ST_RUN);
  end

  // Next-state logic: the run ends once the last sample has updated the stats.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: if (start) next_state = ST_RUN;
      ST_RUN:  if (sample_count == NUM_S) next_state = ST_DONE;
      ST_DONE: if (start) next_state = ST_RUN;
      default: next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Count accepted samples so input stops exactly at the run length.
  always_ff @(posedge clk) begin
    if (rst || clear_run) accepted <= '0;
    else if (accept)      accepted <= accepted + 1'b1;
  end

  // Pipeline valid bits; flushed on reset or when a new run begins.
  always_ff @(posedge clk) begin
    if (rst || clear_run) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
    end
  end

  // Stage 1 captures the exact product next to the approximate one.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_exact  <= PW'(op_a) * PW'(op_b);
      s1_approx <= product;
    end
  end

  abs_diff #(.W(PW)) u_abs_diff (
    .a    (s1_exact),
    .b    (s1_approx),
    .diff (abs_err_comb)
  );

  // Stage 2 registers the absolute error.
  always_ff @(posedge clk) begin
    s2_abs_err <= abs_err_comb;
  end

  // Widen before adding so the saturation test sees the true sum.
  always_comb begin
    sum_wide = ADD_W'(err_sum) + ADD_W'(s2_abs_err);
    sum_sat  = (sum_wide > ADD_W'(SUM_MAX)) ? SUM_MAX : sum_wide[SUM_W-1:0];
  end

  // Stage 3 folds each retiring sample into the run statistics.
  always_ff @(posedge clk) begin
    if (rst || clear_run) begin
      sample_count <= '0;
      err_count    <= '0;
      err_sum      <= '0;
      err_max      <= '0;
    end else if (s2_valid) begin
      sample_count <= sample_count + 1'b1;
      if (s2_abs_err != '0) err_count <= err_count + 1'b1;
      err_sum <= sum_sat;
      if (s2_abs_err > err_max) err_max <= s2_abs_err;
    end
  end

endmodule

// File: tb/tb_mult_error_accumulator.sv
// Directed self-checking bench for mult_error_accumulator (4-sample runs,
// one instance with a wide error sum and one with an 8-bit saturating sum).
module tb_mult_error_accumulator;

  localparam int WIDTH = 6;
  localparam int NS    = 4;
  localparam int SUM_W = 24;
  localparam int SAT_W = 8;
  localparam int CNT_W = 13;
  localparam int PW    = 2 * WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             in_valid;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [PW-1:0]    product;

  logic             in_ready, busy, done;
  logic [CNT_W-1:0] sample_count, err_count;
  logic [SUM_W-1:0] err_sum;
  logic [PW-1:0]    err_max;

  logic             in_ready_s, busy_s, done_s;
  logic [CNT_W-1:0] sample_count_s, err_count_s;
  logic [SAT_W-1:0] err_sum_s;
  logic [PW-1:0]    err_max_s;

  int checks = 0;
  int errors = 0;

  mult_error_accumulator #(
    .WIDTH(WIDTH), .NUM_SAMPLES(NS), .SUM_W(SUM_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .product(product), .busy(busy), .done(done),
    .sample_count(sample_count), .err_count(err_count), .err_sum(err_sum), .err_max(err_max)
  );

  mult_error_accumulator #(
    .WIDTH(WIDTH), .NUM_SAMPLES(NS), .SUM_W(SAT_W), .CNT_W(CNT_W)
  ) dut_sat (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_s),
    .op_a(op_a), .op_b(op_b), .product(product), .busy(busy_s), .done(done_s),
    .sample_count(sample_count_s), .err_count(err_count_s), .err_sum(err_sum_s), .err_max(err_max_s)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [PW-1:0] p);
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    product  = p;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    int n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(done), 32'd1);
  endtask

  task automatic checkStats(input string tag, input int cnt, input int ec, input int es, input int em);
    checkOutput({tag, "_sample_count"}, 32'(sample_count), cnt);
    checkOutput({tag, "_err_count"},    32'(err_count),    ec);
    checkOutput({tag, "_err_sum"},      32'(err_sum),      es);
    checkOutput({tag, "_err_max"},      32'(err_max),      em);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    op_a = '0; op_b = '0; product = '0;
    tick();
    tick();

    $display("[TB] reset state");
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_busy",     32'(busy),     32'd0);
    checkOutput("rst_done",     32'(done),     32'd0);
    checkStats("rst", 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    checkOutput("idle_busy",     32'(busy),     32'd0);
    checkOutput("idle_in_ready", 32'(in_ready), 32'd0);

    $display("[TB] exact products, done latency");
    pulseStart();
    checkOutput("t1_busy",     32'(busy),     32'd1);
    checkOutput("t1_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(6'd1, 6'd1, 12'd1);
    applyStimulus(6'd2, 6'd3, 12'd6);
    applyStimulus(6'd63, 6'd63, 12'd3969);
    applyStimulus(6'd0, 6'd5, 12'd0);
    checkOutput("t1_in_ready_full", 32'(in_ready), 32'd0);
    tick();
    tick();
    checkOutput("t1_done_early", 32'(done), 32'd0);
    checkOutput("t1_count_retired", 32'(sample_count), 32'd4);
    tick();
    checkOutput("t1_done", 32'(done), 32'd1);
    checkOutput("t1_busy_done", 32'(busy), 32'd0);
    checkStats("t1", 4, 0, 0, 0);

    $display("[TB] small errors");
    pulseStart();
    checkOutput("t2_done_drop", 32'(done), 32'd0);
    checkOutput("t2_cleared",   32'(sample_count), 32'd0);
    applyStimulus(6'd63, 6'd63, 12'd3968);
    applyStimulus(6'd10, 6'd10, 12'd96);
    applyStimulus(6'd1, 6'd1, 12'd1);
    applyStimulus(6'd0, 6'd0, 12'd0);
    waitDone("t2_done");
    checkStats("t2", 4, 2, 5, 4);

    $display("[TB] bubbles and dropped input");
    pulseStart();
    applyStimulus(6'd5, 6'd7, 12'd32);
    repeat (3) tick();
    applyStimulus(6'd2, 6'd2, 12'd10);
    tick();
    applyStimulus(6'd63, 6'd1, 12'd63);
    repeat (2) tick();
    checkOutput("t3_in_ready_mid", 32'(in_ready), 32'd1);
    checkOutput("t3_count_mid",    32'(sample_count), 32'd3);
    applyStimulus(6'd8, 6'd8, 12'd0);
    checkOutput("t3_in_ready_full", 32'(in_ready), 32'd0);
    applyStimulus(6'd63, 6'd63, 12'd0);
    waitDone("t3_done");
    checkStats("t3", 4, 3, 73, 64);

    $display("[TB] reset mid-run");
    pulseStart();
    applyStimulus(6'd63, 6'd63, 12'd0);
    applyStimulus(6'd63, 6'd63, 12'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t4_busy",     32'(busy),     32'd0);
    checkOutput("t4_done",     32'(done),     32'd0);
    checkOutput("t4_in_ready", 32'(in_ready), 32'd0);
    checkStats("t4_rst", 0, 0, 0, 0);
    repeat (3) tick();
    checkStats("t4_flushed", 0, 0, 0, 0);
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    checkOutput("t4_rst_wins_busy", 32'(busy), 32'd0);
    pulseStart();
    applyStimulus(6'd1, 6'd1, 12'd1);
    applyStimulus(6'd2, 6'd3, 12'd6);
    applyStimulus(6'd63, 6'd63, 12'd3969);
    applyStimulus(6'd0, 6'd5, 12'd0);
    waitDone("t4_rerun_done");
    checkStats("t4_rerun", 4, 0, 0, 0);

    $display("[TB] start during RUN and DONE");
    pulseStart();
    applyStimulus(6'd5, 6'd7, 12'd32);
    pulseStart();
    checkOutput("t5_busy_ignored", 32'(busy), 32'd1);
    applyStimulus(6'd2, 6'd2, 12'd10);
    applyStimulus(6'd63, 6'd1, 12'd63);
    applyStimulus(6'd8, 6'd8, 12'd0);
    waitDone("t5_done_a");
    checkStats("t5_a", 4, 3, 73, 64);
    pulseStart();
    checkOutput("t5_done_drop", 32'(done), 32'd0);
    checkStats("t5_clear", 0, 0, 0, 0);
    applyStimulus(6'd5, 6'd7, 12'd32);
    applyStimulus(6'd2, 6'd2, 12'd10);
    applyStimulus(6'd63, 6'd1, 12'd63);
    applyStimulus(6'd8, 6'd8, 12'd0);
    waitDone("t5_done_b");
    checkStats("t5_b", 4, 3, 73, 64);

    $display("[TB] saturation");
    pulseStart();
    repeat (4) applyStimulus(6'd63, 6'd63, 12'd0);
    waitDone("t6_done");
    checkStats("t6_wide", 4, 4, 15876, 3969);
    checkOutput("t6_sat_err_sum",      32'(err_sum_s),      32'd255);
    checkOutput("t6_sat_err_max",      32'(err_max_s),      32'd3969);
    checkOutput("t6_sat_err_count",    32'(err_count_s),    32'd4);
    checkOutput("t6_sat_sample_count", 32'(sample_count_s), 32'd4);
    checkOutput("t6_sat_done",         32'(done_s),         32'd1);
    checkOutput("t6_sat_busy",         32'(busy_s),         32'd0);
    checkOutput("t6_sat_in_ready",     32'(in_ready_s),     32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
